// File: rtl/conv_sequencer.sv
// Convolution pass sequencer: walks output pixels and filter taps, issuing paired
// image/filter reads, MAC first/last strobes and one output write per pixel.
module conv_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int ACC_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trigger_accel,
  input  logic              hold,
  input  logic [7:0]        image_dim,
  input  logic [8:0]        image_depth,
  input  logic [1:0]        filter_halfsize,
  input  logic [2:0]        filter_stride,
  input  logic [ADDR_W-1:0] image_memory_offset,
  input  logic [ADDR_W-1:0] filter_memory_offset,
  input  logic [ADDR_W-1:0] output_memory_offset,
  output logic [ADDR_W-1:0] img_rd_addr,
  output logic [ADDR_W-1:0] flt_rd_addr,
  output logic              rd_en,
  output logic              tap_valid,
  output logic              tap_first,
  output logic              tap_last,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic              out_wr_en,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        r_state;
  logic [7:0]        r_dim;
  logic [8:0]        r_depth;
  logic [2:0]        r_k;
  logic [2:0]        r_stride;
  logic [ADDR_W-1:0] r_img_off;
  logic [ADDR_W-1:0] r_flt_off;
  logic [ADDR_W-1:0] r_out_off;
  logic [8:0]        r_d;
  logic [2:0]        r_kx;
  logic [2:0]        r_ky;
  logic [7:0]        r_ox;
  logic [7:0]        r_oy;
  logic [ADDR_W-1:0] r_pix;
  logic [7:0]        r_drain;
  logic              r_tap_valid;
  logic              r_tap_first;
  logic              r_tap_last;
  logic              r_out_wr_en;
  logic [ADDR_W-1:0] r_out_wr_addr;
  logic              r_busy;
  logic              r_done;

  logic [2:0]        w_state_nxt;
  logic              w_issue;
  logic              w_tap_first;
  logic              w_tap_last;
  logic [8:0]        w_k9;
  logic [8:0]        w_dim9;
  logic [8:0]        w_ox_step;
  logic [8:0]        w_oy_step;
  logic              w_row_wrap;
  logic              w_pass_end;
  logic [8:0]        w_y;
  logic [8:0]        w_x;
  logic [ADDR_W-1:0] w_img_lin;
  logic [ADDR_W-1:0] w_flt_lin;
  logic [ADDR_W-1:0] w_img_addr;
  logic [ADDR_W-1:0] w_flt_addr;

  // Origin arithmetic is 9 bits wide so ox + stride + K cannot wrap at dim = 255.
  assign w_k9      = {6'd0, r_k};
  assign w_dim9    = {1'b0, r_dim};
  assign w_ox_step = {1'b0, r_ox} + {6'd0, r_stride};
  assign w_oy_step = {1'b0, r_oy} + {6'd0, r_stride};
  assign w_row_wrap = (w_ox_step + w_k9) > w_dim9;
  assign w_pass_end = (w_oy_step + w_k9) > w_dim9;

  assign w_issue     = (r_state == S_RUN) && !hold;
  assign w_tap_first = (r_d == 9'd0) && (r_kx == 3'd0) && (r_ky == 3'd0);
  assign w_tap_last  = (r_d == r_depth - 9'd1) && (r_kx == r_k - 3'd1) && (r_ky == r_k - 3'd1);

  // Channel-last addressing; every product and sum wraps at ADDR_W bits.
  assign w_y        = {1'b0, r_oy} + {6'd0, r_ky};
  assign w_x        = {1'b0, r_ox} + {6'd0, r_kx};
  assign w_img_lin  = ADDR_W'(w_y) * ADDR_W'(r_dim) + ADDR_W'(w_x);
  assign w_flt_lin  = ADDR_W'(r_ky) * ADDR_W'(r_k) + ADDR_W'(r_kx);
  assign w_img_addr = r_img_off + w_img_lin * ADDR_W'(r_depth) + ADDR_W'(r_d);
  assign w_flt_addr = r_flt_off + w_flt_lin * ADDR_W'(r_depth) + ADDR_W'(r_d);

  assign img_rd_addr = (r_state == S_RUN) ? w_img_addr : '0;
  assign flt_rd_addr = (r_state == S_RUN) ? w_flt_addr : '0;
  assign rd_en       = w_issue;
  assign tap_valid   = r_tap_valid;
  assign tap_first   = r_tap_first;
  assign tap_last    = r_tap_last;
  assign out_wr_en   = r_out_wr_en;
  assign out_wr_addr = r_out_wr_addr;
  assign busy        = r_busy;
  assign done        = r_done;

  // Next-state decode of the pass sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (trigger_accel) w_state_nxt = S_SETUP; else w_state_nxt = S_IDLE;
      S_SETUP: if (w_k9 > w_dim9) w_state_nxt = S_DONE; else w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && w_tap_last) w_state_nxt = S_DRAIN; else w_state_nxt = S_RUN;
      S_DRAIN: if (r_drain == 8'(ACC_LATENCY)) w_state_nxt = S_WRITE; else w_state_nxt = S_DRAIN;
      S_WRITE: if (w_row_wrap && w_pass_end) w_state_nxt = S_DONE; else w_state_nxt = S_RUN;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, latched configuration, loop counters and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_dim         <= 8'd0;
      r_depth       <= 9'd0;
      r_k           <= 3'd0;
      r_stride      <= 3'd0;
      r_img_off     <= '0;
      r_flt_off     <= '0;
      r_out_off     <= '0;
      r_d           <= 9'd0;
      r_kx          <= 3'd0;
      r_ky          <= 3'd0;
      r_ox          <= 8'd0;
      r_oy          <= 8'd0;
      r_pix         <= '0;
      r_drain       <= 8'd0;
      r_tap_valid   <= 1'b0;
      r_tap_first   <= 1'b0;
      r_tap_last    <= 1'b0;
      r_out_wr_en   <= 1'b0;
      r_out_wr_addr <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tap_valid   <= w_issue;
      r_tap_first   <= w_issue && w_tap_first;
      r_tap_last    <= w_issue && w_tap_last;
      r_busy        <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done        <= (w_state_nxt == S_DONE);
      r_out_wr_en   <= (w_state_nxt == S_WRITE);
      r_out_wr_addr <= (w_state_nxt == S_WRITE) ? (r_out_off + r_pix) : '0;
      case (r_state)
        S_IDLE: begin
          if (trigger_accel) begin
            r_dim     <= image_dim;
            r_depth   <= (image_depth == 9'd0) ? 9'd1 : image_depth;
            r_k       <= {filter_halfsize, 1'b1};
            r_stride  <= (filter_stride == 3'd0) ? 3'd1 : filter_stride;
            r_img_off <= image_memory_offset;
            r_flt_off <= filter_memory_offset;
            r_out_off <= output_memory_offset;
          end
        end
        S_SETUP: begin
          r_d     <= 9'd0;
          r_kx    <= 3'd0;
          r_ky    <= 3'd0;
          r_ox    <= 8'd0;
          r_oy    <= 8'd0;
          r_pix   <= '0;
          r_drain <= 8'd0;
        end
        S_RUN: begin
          if (w_issue) begin
            if (w_tap_last) begin
              r_d     <= 9'd0;
              r_kx    <= 3'd0;
              r_ky    <= 3'd0;
              r_drain <= 8'd0;
            end else if (r_d == r_depth - 9'd1) begin
              r_d <= 9'd0;
              if (r_kx == r_k - 3'd1) begin
                r_kx <= 3'd0;
                r_ky <= r_ky + 3'd1;
              end else begin
                r_kx <= r_kx + 3'd1;
              end
            end else begin
              r_d <= r_d + 9'd1;
            end
          end
        end
        S_DRAIN: r_drain <= r_drain + 8'd1;
        S_WRITE: begin
          r_pix <= r_pix + ADDR_W'(1'b1);
          if (w_row_wrap) begin
            r_ox <= 8'd0;
            r_oy <= w_oy_step[7:0];
          end else begin
            r_ox <= w_ox_step[7:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: a queue-based reference of the expected read/write
// address streams and pass latency, checked every cycle against the DUT.
module tb_conv_sequencer;
  localparam int ADDR_W = 16;
  localparam int ACC    = 2;

  logic              clk, rst, trigger_accel, hold;
  logic [7:0]        image_dim;
  logic [8:0]        image_depth;
  logic [1:0]        filter_halfsize;
  logic [2:0]        filter_stride;
  logic [ADDR_W-1:0] image_memory_offset, filter_memory_offset, output_memory_offset;
  logic [ADDR_W-1:0] img_rd_addr, flt_rd_addr, out_wr_addr;
  logic              rd_en, tap_valid, tap_first, tap_last, out_wr_en, busy, done;

  conv_sequencer #(.ADDR_W(ADDR_W), .ACC_LATENCY(ACC)) dut (
    .clk(clk), .rst(rst), .trigger_accel(trigger_accel), .hold(hold),
    .image_dim(image_dim), .image_depth(image_depth),
    .filter_halfsize(filter_halfsize), .filter_stride(filter_stride),
    .image_memory_offset(image_memory_offset), .filter_memory_offset(filter_memory_offset),
    .output_memory_offset(output_memory_offset),
    .img_rd_addr(img_rd_addr), .flt_rd_addr(flt_rd_addr), .rd_en(rd_en),
    .tap_valid(tap_valid), .tap_first(tap_first), .tap_last(tap_last),
    .out_wr_addr(out_wr_addr), .out_wr_en(out_wr_en), .busy(busy), .done(done)
  );

  int nchecks = 0;
  int nerrs   = 0;
  int cyc     = 0;
  int exp_img[$], exp_flt[$], exp_wr[$];
  int obs_img[$], obs_flt[$], obs_wr[$];
  int taps = 1, exp_lat = 0, trig_cyc = 0, last_issue_cyc = 0, issue_idx = 0;
  int first_cnt = 0, last_cnt = 0, done_lat = -1;
  bit pass_active = 0, seen_done = 0, prev_rd = 0, prev_first = 0, prev_last = 0;
  int t1_img[9] = '{32'h100, 32'h101, 32'h102, 32'h104, 32'h105, 32'h106, 32'h108, 32'h109, 32'h10A};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input int act, input int req);
    nchecks++;
    if (act != req) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: enumerate every output origin and tap in loop order with plain arithmetic.
  task automatic build_model(input int dim, input int h, input int stride, input int depth,
                             input int ioff, input int foff, input int ooff);
    int k, s, dp, pix;
    k  = 2 * h + 1;
    s  = (stride == 0) ? 1 : stride;
    dp = (depth == 0) ? 1 : depth;
    exp_img.delete(); exp_flt.delete(); exp_wr.delete();
    taps = k * k * dp;
    pix  = 0;
    if (k <= dim) begin
      for (int oy = 0; oy + k <= dim; oy += s)
        for (int ox = 0; ox + k <= dim; ox += s) begin
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++)
              for (int d = 0; d < dp; d++) begin
                exp_img.push_back((ioff + ((oy + ky) * dim + ox + kx) * dp + d) & 32'hFFFF);
                exp_flt.push_back((foff + (ky * k + kx) * dp + d) & 32'hFFFF);
              end
          exp_wr.push_back((ooff + pix) & 32'hFFFF);
          pix++;
        end
    end
    exp_lat = 2 + pix * (taps + 2 + ACC);
  endtask

  task automatic start_pass(input int dim, input int h, input int stride, input int depth,
                            input int ioff, input int foff, input int ooff);
    build_model(dim, h, stride, depth, ioff, foff, ooff);
    obs_img.delete(); obs_flt.delete(); obs_wr.delete();
    first_cnt = 0; last_cnt = 0; issue_idx = 0; done_lat = -1; seen_done = 0;
    @(posedge clk); #1;
    image_dim            = 8'(dim);
    filter_halfsize      = 2'(h);
    filter_stride        = 3'(stride);
    image_depth          = 9'(depth);
    image_memory_offset  = 16'(ioff);
    filter_memory_offset = 16'(foff);
    output_memory_offset = 16'(ooff);
    trigger_accel = 1'b1;
    trig_cyc      = cyc;
    pass_active   = 1'b1;
    @(posedge clk); #1;
    trigger_accel = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !seen_done; i++) @(posedge clk);
    chk("done_seen", seen_done, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_taps(input int n);
    for (int i = 0; i < 300 && obs_img.size() < n; i++) @(posedge clk);
    chk("taps_reached", obs_img.size() >= n, 1);
  endtask

  // Per-cycle comparison of DUT outputs against the reference streams.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("reset_outputs", ((img_rd_addr | flt_rd_addr | out_wr_addr) != 0) ||
          rd_en || tap_valid || tap_first || tap_last || out_wr_en || busy || done, 0);
      prev_rd = 0; prev_first = 0; prev_last = 0;
    end else begin
      chk("tap_valid", tap_valid, prev_rd);
      chk("tap_first", tap_first, prev_rd && prev_first);
      chk("tap_last", tap_last, prev_rd && prev_last);
      if (tap_first) first_cnt++;
      if (tap_last) last_cnt++;
      if (!pass_active) chk("idle_quiet", rd_en || out_wr_en || busy || done, 0);
      prev_rd = rd_en; prev_first = 0; prev_last = 0;
      if (rd_en) begin
        chk("rd_while_hold", hold, 0);
        chk("rd_busy", busy, 1);
        obs_img.push_back(img_rd_addr);
        obs_flt.push_back(flt_rd_addr);
        chk("taps_left", exp_img.size() > 0, 1);
        if (exp_img.size() > 0) begin
          chk("img_addr", img_rd_addr, exp_img.pop_front());
          chk("flt_addr", flt_rd_addr, exp_flt.pop_front());
        end
        prev_first = (issue_idx % taps) == 0;
        prev_last  = (issue_idx % taps) == taps - 1;
        if (prev_last) last_issue_cyc = cyc;
        issue_idx++;
      end
      if (out_wr_en) begin
        obs_wr.push_back(out_wr_addr);
        chk("wr_left", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) chk("wr_addr", out_wr_addr, exp_wr.pop_front());
        chk("drain_gap", cyc - last_issue_cyc, 2 + ACC);
        chk("wr_busy", busy, 1);
      end
      if (done) begin
        done_lat = cyc - trig_cyc;
        chk("done_latency", done_lat, exp_lat);
        chk("done_busy", busy, 0);
        chk("taps_remaining", exp_img.size(), 0);
        chk("wr_remaining", exp_wr.size(), 0);
        seen_done   = 1;
        pass_active = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; trigger_accel = 1'b0; hold = 1'b0;
    image_dim = 8'd0; image_depth = 9'd0; filter_halfsize = 2'd0; filter_stride = 3'd0;
    image_memory_offset = 16'd0; filter_memory_offset = 16'd0; output_memory_offset = 16'd0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_busy", busy, 0);

    // Basic pass
    start_pass(4, 1, 1, 1, 32'h100, 32'h200, 32'h300);
    wait_done(200);
    chk("t1_ntaps", obs_img.size(), 36);
    if (obs_img.size() >= 9)
      for (int i = 0; i < 9; i++) chk("t1_img_lit", obs_img[i], t1_img[i]);
    if (obs_flt.size() >= 9) chk("t1_flt8", obs_flt[8], 32'h208);
    chk("t1_nwr", obs_wr.size(), 4);
    if (obs_wr.size() == 4) chk("t1_wr3", obs_wr[3], 32'h303);
    chk("t1_done_lat", done_lat, 54);
    chk("t1_first_cnt", first_cnt, 4);
    chk("t1_last_cnt", last_cnt, 4);

    // Stride 2, depth 2
    start_pass(5, 1, 2, 2, 32'h1000, 32'h2000, 32'h3000);
    wait_done(300);
    chk("t2_ntaps", obs_img.size(), 72);
    if (obs_img.size() == 72) begin
      chk("t2_px1_first", obs_img[18], 32'h1004);
      chk("t2_px2_first", obs_img[36], 32'h1014);
      chk("t2_px3_first", obs_img[54], 32'h1018);
    end
    chk("t2_nwr", obs_wr.size(), 4);

    // Kernel larger than image
    start_pass(2, 1, 1, 1, 32'h100, 32'h200, 32'h300);
    wait_done(20);
    chk("t3_done_lat", done_lat, 2);
    chk("t3_ntaps", obs_img.size(), 0);
    chk("t3_nwr", obs_wr.size(), 0);

    // Stride 0 and depth 0 behave as 1
    start_pass(3, 0, 0, 0, 32'h40, 32'h80, 32'hC0);
    wait_done(200);
    chk("t4_nwr", obs_wr.size(), 9);
    chk("t4_done_lat", done_lat, 47);
    if (obs_img.size() == 9) begin
      chk("t4_img4", obs_img[4], 32'h44);
      chk("t4_flt4", obs_flt[4], 32'h80);
    end

    // Hold for 3 cycles mid-pixel
    start_pass(4, 1, 1, 1, 32'h100, 32'h200, 32'h300);
    wait_taps(4);
    #1 hold = 1'b1;
    exp_lat += 3;
    repeat (3) @(posedge clk);
    #1 hold = 1'b0;
    wait_done(200);
    chk("t5_done_lat", done_lat, 57);
    chk("t5_first_cnt", first_cnt, 4);
    chk("t5_last_cnt", last_cnt, 4);

    // Retrigger and input changes during a pass are ignored
    start_pass(4, 1, 1, 1, 32'h100, 32'h200, 32'h300);
    repeat (10) @(posedge clk);
    #1;
    trigger_accel = 1'b1; image_dim = 8'd5; filter_halfsize = 2'd0;
    image_memory_offset = 16'h5000;
    @(posedge clk); #1;
    trigger_accel = 1'b0;
    wait_done(200);
    chk("t6_done_lat", done_lat, 54);
    chk("t6_ntaps", obs_img.size(), 36);
    if (obs_img.size() == 36) chk("t6_last_img", obs_img[35], 32'h10F);

    // Asynchronous reset mid-run, then a fresh pass
    start_pass(4, 1, 1, 1, 32'h100, 32'h200, 32'h300);
    wait_taps(5);
    #1 rst = 1'b0;
    pass_active = 1'b0;
    #1;
    chk("async_reset", (img_rd_addr != 0) || rd_en || tap_valid || busy || out_wr_en || done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    start_pass(4, 1, 1, 1, 32'h100, 32'h200, 32'h300);
    wait_done(200);
    if (obs_img.size() > 0) chk("t7_restart_img0", obs_img[0], 32'h100);
    if (obs_wr.size() > 0) chk("t7_restart_wr0", obs_wr[0], 32'h300);
    chk("t7_done_lat", done_lat, 54);

    // Address wrap at 2^16
    start_pass(3, 1, 1, 1, 32'hFFFE, 32'h10, 32'h20);
    wait_done(100);
    if (obs_img.size() >= 4) begin
      chk("t8_wrap0", obs_img[0], 32'hFFFE);
      chk("t8_wrap1", obs_img[1], 32'hFFFF);
      chk("t8_wrap2", obs_img[2], 32'h0000);
      chk("t8_wrap3", obs_img[3], 32'h0001);
    end
    chk("t8_nwr", obs_wr.size(), 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Sequences one convolution pass of the accelerator after the host interface fires `trigger_accel`.
- Walks every valid output pixel and every filter tap, issuing paired image/filter read addresses to the on-chip memory.
- Drives first/last/valid strobes to the external MAC accumulator, then issues one output write per pixel and pulses `done`.
- Sits between the interface register block and the memory/MAC datapath.

Parameters:
- ADDR_W, 16, width of all memory addresses and offsets.
- ACC_LATENCY, 2, cycles from tap_last at the MAC input to the accumulated result being valid.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- trigger_accel  input  1  one-cycle start pulse.
- hold  input  1  memory port claimed elsewhere; no new tap issued while high.
- image_dim  input  8  square image side length.
- image_depth  input  9  channels; 0 treated as 1.
- filter_halfsize  input  2  h; kernel side K = 2h+1.
- filter_stride  input  3  stride; 0 treated as 1.
- image_memory_offset  input  ADDR_W  image base address.
- filter_memory_offset  input  ADDR_W  filter base address.
- output_memory_offset  input  ADDR_W  output base address.
- img_rd_addr  output  ADDR_W  image read address.
- flt_rd_addr  output  ADDR_W  filter read address.
- rd_en  output  1  read strobe; data returns exactly 1 cycle later.
- tap_valid  output  1  memory data this cycle is a valid tap.
- tap_first  output  1  first tap of a pixel; clears the accumulator.
- tap_last  output  1  last tap of a pixel.
- out_wr_addr  output  ADDR_W  output write address.
- out_wr_en  output  1  one-cycle write strobe for the accumulator result.
- busy  output  1  high from the cycle after the trigger until done.
- done  output  1  one-cycle end-of-pass pulse.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-pass aborts immediately; no further strobes.
- Memory layout is channel-last:
  - image addr = image_off + (y*dim + x)*depth + d
  - filter addr = filter_off + (ky*K + kx)*depth + d
  - all sums wrap modulo 2^ADDR_W.
- Config is latched on trigger. Trigger is ignored unless the state is IDLE; input changes during a pass have no effect.
- IDLE -> SETUP on trigger. SETUP takes 1 cycle, zeroes the counters and sets origin oy=ox=0.
  - If K > dim: -> DONE, with no tap or write strobes.
  - Else: -> RUN.
- RUN issues one tap per cycle while hold=0 (rd_en=1); with hold=1, rd_en=0 and counters freeze.
  - Loop order, innermost first: d, kx, ky.
  - Pixel located at y = oy + ky, x = ox + kx.
  - After the last tap (ky = kx = K-1, d = depth-1) -> DRAIN.
- Tap strobes:
  - tap_valid = rd_en delayed 1 cycle.
  - tap_first/tap_last = the registered "first issued"/"last issued" flags, aligned with tap_valid.
  - hold gaps create tap_valid=0 bubbles; first/last stay exact.
- DRAIN waits 1 + ACC_LATENCY cycles after the last issue, then -> WRITE.
- WRITE lasts 1 cycle:
  - out_wr_en=1, out_wr_addr = output_off + pixel_index (row-major over outputs, starting at 0).
  - pixel_index increments; ox += stride.
  - If ox + K > dim: ox = 0, oy += stride.
  - If oy + K > dim: -> DONE, else -> RUN.
- Origin comparisons use 9-bit arithmetic to avoid overflow at dim=255.
- DONE lasts 1 cycle: done=1, then -> IDLE; busy drops in the same cycle.
- Cycles per pixel, with no hold: taps + 1 + ACC_LATENCY + 1, where taps = K*K*depth.

Test Plan:
- Basic pass, dim=4, h=1, stride=1, depth=1, offsets 0x100/0x200/0x300, ACC_LATENCY=2:
  - pixel 0 image addrs 0x100,101,102,104,105,106,108,109,10A; filter addrs 0x200..0x208.
  - 4 writes to 0x300..0x303; 13 cycles per pixel.
  - done 54 cycles after trigger.
- Stride and depth, dim=5, h=1, stride=2, depth=2:
  - output origins (0,0),(0,2),(2,0),(2,2); 18 taps per pixel.
  - pixel 1 first image addr = off + 4.
  - 4 writes total.
- Degenerate sizes:
  - dim=2, h=1: done 2 cycles after trigger; no rd_en, no out_wr_en.
  - stride=0 and depth=0 behave as 1.
- Hold during RUN: hold high 3 cycles mid-pixel.
  - Address sequence unchanged; 3 tap_valid bubbles.
  - tap_first/tap_last counts exactly 1 per pixel.
  - Pixel takes 3 extra cycles.
- Retrigger and reset:
  - trigger while busy is ignored and the pass completes normally.
  - rst low mid-RUN zeroes all outputs asynchronously.
  - A fresh trigger after reset restarts from pixel 0.
- Wrap: image_off=0xFFFE, dim=3, h=1 → addresses wrap 0xFFFE, 0xFFFF, 0x0000...
